// File: rtl/count_disp_pkg.sv
// Shared constants and types for the counter display stage: segment glyph
// table, blank pattern, active-low digit enables and the digit-select type.
package count_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_D0     = 2'b10;
    localparam logic [1:0] AN_D1     = 2'b01;
    localparam logic [1:0] AN_OFF    = 2'b11;

    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } digit_sel_e;

    // Active-low glyphs, bit0 = segment a ... bit6 = segment g.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module hex_to_seg7
    import count_disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_SEG[hex_i];
    end

endmodule

// File: rtl/count_disp_scan.sv
// Display stage for the up/down counter: tracks carry/borrow events in a high
// digit and time-multiplexes q and hi onto a two-digit common-anode display.
// Optional: define COUNT_DISP_BLANK_LEAD_ZERO_EN to blank digit1 when hi is 0.
module count_disp_scan
    import count_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned HI_W     = 4
) (
    input  logic            clk,
    input  logic            mr,
    input  logic [3:0]      q,
    input  logic            co,
    input  logic            up_dn,
    output logic [HI_W-1:0] hi,
    output logic [6:0]      seg,
    output logic [1:0]      an
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [HI_W-1:0] hi_q, hi_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    digit_sel_e      sel_q, sel_d;
    logic            co_d_q;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;

    logic            co_event;
    logic [3:0]      digit_val;
    logic [6:0]      digit_glyph;

    hex_to_seg7 u_dec (
        .hex_i (digit_val),
        .seg_o (digit_glyph)
    );

    always_comb begin
        co_event  = co & ~co_d_q;
        digit_val = (sel_q == DIG1) ? hi_q[3:0] : q;

        hi_d = hi_q;
        if (co_event) begin
            hi_d = up_dn ? (hi_q - 1'b1) : (hi_q + 1'b1);
        end

        cnt_d = cnt_q + 1'b1;
        sel_d = sel_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            sel_d = (sel_q == DIG0) ? DIG1 : DIG0;
        end

        // Output stage reflects the current (pre-toggle) select, giving one
        // cycle of latency from sel/q/hi to the pins.
        an_d  = (sel_q == DIG1) ? AN_D1 : AN_D0;
        seg_d = digit_glyph;
`ifdef COUNT_DISP_BLANK_LEAD_ZERO_EN
        if ((sel_q == DIG1) && (hi_q == '0)) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mr) begin
            hi_q   <= '0;
            cnt_q  <= '0;
            sel_q  <= DIG0;
            co_d_q <= 1'b0;
            seg_q  <= SEG_BLANK;
            an_q   <= AN_OFF;
        end else begin
            hi_q   <= hi_d;
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            co_d_q <= co;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign hi  = hi_q;
    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: doc/count_disp_scan.md
Name: count_disp_scan

Overview:
- Downstream display stage for the 4-bit up/down counter.
- Consumes the counter's q, co and up_dn, and tracks wrap/borrow events in a 4-bit high-digit register.
- Time-multiplexes two hex digits onto one common-anode seven-segment display: digit0 shows q, digit1 shows the high digit.
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays lit; legal range 2 to 2^20.
- HI_W, 4, width of the high-digit register; fixed at 4 for hex display.

Ports:
- clk  in  1  system clock, rising edge.
- mr  in  1  reset: one clock; reset is synchronous and active-high.
- q  in  4  counter value, shown on digit0.
- co  in  1  counter carry/borrow flag.
- up_dn  in  1  counter direction; 0 = up, 1 = down.
- hi  out  4  high-digit register, i.e. the count of co events.
- seg  out  7  segment drive, active-low; bit0 = a … bit6 = g.
- an  out  2  digit enables, active-low; an[0] = digit0, an[1] = digit1.

Behaviour:
- Reset (mr high at a clk edge): hi=0, scan counter=0, sel=0, co_d=0, seg=7'h7F (blank), an=2'b11 (both off). Reset has priority over every other event in the same cycle.
- Carry edge detection:
  - co_d <= co every cycle.
  - Event = co & ~co_d. A held co (counter disabled) gives exactly one event.
- On an event, up_dn is sampled in the same cycle:
  - up_dn=0: hi <= hi+1, wrapping F->0.
  - up_dn=1: hi <= hi-1, wrapping 0->F.
- hi is updated registered, 1 cycle after the co rising edge.
- Scan counter:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap cycle, sel toggles.
- Output register, every cycle outside reset:
  - an <= ~(2'b01 << sel).
  - seg <= decode(sel ? hi : q).
  - seg and an are registered: 1-cycle latency from sel, q or hi to pins.
  - The first non-reset cycle after mr deasserts drives an=2'b10 with digit0 content.
- Decode: standard hex glyphs 0-F, e.g. 0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00, F -> 7'h0E.
- q is treated as already synchronous to clk; there is no internal synchronizer.
- Simultaneous event and scan wrap: both take effect. The new hi appears on pins one cycle after it is registered, if digit1 is selected.
- Reset mid-scan: the scan phase restarts at digit0 and the counter restarts from 0.

Optional Feature:
- Macro: COUNT_DISP_BLANK_LEAD_ZERO_EN.
- Defined: when sel=1 and hi==0, seg <= 7'h7F (leading-zero blank). an timing is unchanged.
- Undefined: digit1 always shows the hi glyph, including "0" (7'h40).

Decomposition:
- Shared package count_disp_pkg holds:
  - SEG_BLANK = 7'h7F.
  - the 16-entry hex-to-segment constant table.
  - digit-select typedef (1 bit).
  - active-low enable constants AN_D0 = 2'b10, AN_D1 = 2'b01.
- Sub-module hex_to_seg7: combinational 4-bit to 7-bit decoder using the package table, instanced once.

Test Plan (SCAN_DIV=4 in simulation):
- Reset check: assert mr for 3 cycles with q=5 -> seg=7'h7F, an=2'b11, hi=0. The cycle after release -> an=2'b10, seg=7'h12 (glyph 5).
- Scan cadence: hold q=3. an alternates 2'b10/2'b01 every 4 cycles; digit1 shows hi=0 as 7'h40 (macro undefined).
- Up carry: up_dn=0, pulse co high for 1 cycle -> hi=1 one cycle later. Hold co high 10 cycles -> hi remains 1 (single event).
- Down borrow with wrap: from hi=0, up_dn=1, one co edge -> hi=F. While sel=1, seg=7'h0E.
- Up wrap: 16 co edges with up_dn=0 starting at hi=0 -> hi=0 again.
- Collision and reset: a co edge coincides with mr=1 -> hi=0 and no increment. With COUNT_DISP_BLANK_LEAD_ZERO_EN defined, hi=0 and sel=1 -> seg=7'h7F, an=2'b01.
